// File: rtl/nav_pkg.sv
// Shared encodings for the grid navigator: one-hot FSM states, reel motor codes,
// axis direction polarities and the reel phase decode used during the dwell.
package nav_pkg;

  typedef enum logic [5:0] {
    S_IDLE   = 6'b000001,
    S_MOVE_X = 6'b000010,
    S_MOVE_Y = 6'b000100,
    S_PAUSE  = 6'b001000,
    S_RET_X  = 6'b010000,
    S_RET_Y  = 6'b100000
  } nav_state_e;

  typedef enum logic [1:0] {
    MOTOR_STOP = 2'b00,
    MOTOR_FWD  = 2'b01,
    MOTOR_REV  = 2'b10
  } motor_state_e;

  localparam logic X_DIR_POS = 1'b1;
  localparam logic X_DIR_NEG = 1'b0;
  localparam logic Y_DIR_POS = 1'b0;
  localparam logic Y_DIR_NEG = 1'b1;

  // remaining counts down from pause_ticks to 1; additions avoid underflow.
  function automatic motor_state_e reel_phase(input logic [63:0] remaining,
                                              input logic [63:0] pause_ticks,
                                              input logic [63:0] reel_ticks);
    motor_state_e m;
    if (remaining + reel_ticks > pause_ticks)
      m = MOTOR_REV;
    else if (remaining + (reel_ticks << 1) > pause_ticks)
      m = MOTOR_FWD;
    else
      m = MOTOR_STOP;
    return m;
  endfunction

endpackage

// File: rtl/nav_unit_timer.sv
// Loadable down counter shared by the move and dwell phases; o_expire is a registered
// pulse that is high during the last counted cycle of a loaded interval.
module nav_unit_timer
  import nav_pkg::*;
#(
  parameter int unsigned TIMER_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic               i_en,
  input  logic [TIMER_W-1:0] i_load_val,
  output logic               o_expire,
  output logic [TIMER_W-1:0] o_count
);

  localparam logic [TIMER_W-1:0] T_ONE = TIMER_W'(1);
  localparam logic [TIMER_W-1:0] T_TWO = TIMER_W'(2);

  logic [TIMER_W-1:0] r_count;
  logic               r_expire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= '0;
      r_expire <= 1'b0;
    end else if (i_load) begin
      r_count  <= i_load_val;
      r_expire <= (i_load_val == T_ONE);
    end else if (i_en) begin
      r_count  <= (r_count != '0) ? r_count - T_ONE : '0;
      r_expire <= (r_count == T_TWO);
    end else begin
      r_expire <= 1'b0;
    end
  end

  assign o_expire = r_expire;
  assign o_count  = r_count;

endmodule

// File: rtl/grid_nav_controller.sv
// Open-loop X/Y gantry navigator: move X then Y to the target, run the reel dwell, return home.
// Optional COORD_CHAIN_EN: accept the next target during the dwell and travel there directly.
module grid_nav_controller
  import nav_pkg::*;
#(
  parameter int unsigned     COORD_W      = 3,
  parameter int unsigned     MAX_X        = 7,
  parameter int unsigned     MAX_Y        = 7,
  parameter int unsigned     TIMER_W      = 32,
  parameter longint unsigned X_UNIT_TICKS = 64'd98_350_000,
  parameter longint unsigned Y_UNIT_TICKS = 64'd136_650_000,
  parameter longint unsigned PAUSE_TICKS  = 64'd3_000_000_000,
  parameter longint unsigned REEL_TICKS   = 64'd1_450_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [COORD_W-1:0] cmd_x,
  input  logic [COORD_W-1:0] cmd_y,
  input  logic               abort,
  output logic               x_run,
  output logic               x_dir,
  output logic               y_run,
  output logic               y_dir,
  output logic               motor_en,
  output logic [1:0]         motor_state,
  output logic               busy,
  output logic               done,
  output logic [COORD_W-1:0] pos_x,
  output logic [COORD_W-1:0] pos_y
);

  localparam logic [COORD_W-1:0] C_MAX_X = COORD_W'(MAX_X);
  localparam logic [COORD_W-1:0] C_MAX_Y = COORD_W'(MAX_Y);
  localparam logic [COORD_W-1:0] C_ONE   = COORD_W'(1);
  localparam logic [TIMER_W-1:0] T_X     = TIMER_W'(X_UNIT_TICKS);
  localparam logic [TIMER_W-1:0] T_Y     = TIMER_W'(Y_UNIT_TICKS);
  localparam logic [TIMER_W-1:0] T_PAUSE = TIMER_W'(PAUSE_TICKS);
  localparam logic [TIMER_W-1:0] T_ONE   = TIMER_W'(1);

  nav_state_e         r_state, w_state_nxt;
  logic [COORD_W-1:0] r_pos_x, r_pos_y, r_tx, r_ty;
  logic [COORD_W-1:0] w_pos_x_nxt, w_pos_y_nxt, w_tx_nxt, w_ty_nxt;
  logic [COORD_W-1:0] w_cmd_tx, w_cmd_ty;
  logic               r_cmd_ready, r_x_run, r_x_dir, r_y_run, r_y_dir;
  logic               r_motor_en, r_busy, r_done;
  motor_state_e       r_motor_state;
  logic               w_accept, w_fwd, w_home, w_load, w_expire, w_timer_en;
  logic [TIMER_W-1:0] w_load_val, w_count, w_remaining_nxt;
`ifdef COORD_CHAIN_EN
  logic               r_buf_full, w_buf_full_nxt;
  logic [COORD_W-1:0] r_buf_x, r_buf_y, w_buf_x_nxt, w_buf_y_nxt;
`endif

  assign w_accept   = cmd_valid & r_cmd_ready;
  assign w_cmd_tx   = (cmd_x > C_MAX_X) ? C_MAX_X : cmd_x;
  assign w_cmd_ty   = (cmd_y > C_MAX_Y) ? C_MAX_Y : cmd_y;
  assign w_timer_en = (r_state != S_IDLE);

  nav_unit_timer #(.TIMER_W(TIMER_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_en       (w_timer_en),
    .i_load_val (w_load_val),
    .o_expire   (w_expire),
    .o_count    (w_count)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_pos_x_nxt = r_pos_x;
    w_pos_y_nxt = r_pos_y;
    w_tx_nxt    = r_tx;
    w_ty_nxt    = r_ty;
    w_fwd       = 1'b0;
    w_home      = 1'b0;
`ifdef COORD_CHAIN_EN
    w_buf_full_nxt = r_buf_full;
    w_buf_x_nxt    = r_buf_x;
    w_buf_y_nxt    = r_buf_y;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_tx_nxt = w_cmd_tx;
          w_ty_nxt = w_cmd_ty;
          w_fwd    = 1'b1;
        end
      end
      S_MOVE_X: begin
        if (w_expire)
          w_pos_x_nxt = (r_tx > r_pos_x) ? r_pos_x + C_ONE : r_pos_x - C_ONE;
        if (abort)
          w_home = 1'b1;
        else if (w_expire && (w_pos_x_nxt == r_tx))
          w_fwd = 1'b1;
      end
      S_MOVE_Y: begin
        if (w_expire)
          w_pos_y_nxt = (r_ty > r_pos_y) ? r_pos_y + C_ONE : r_pos_y - C_ONE;
        if (abort)
          w_home = 1'b1;
        else if (w_expire && (w_pos_y_nxt == r_ty))
          w_fwd = 1'b1;
      end
      S_PAUSE: begin
`ifdef COORD_CHAIN_EN
        // A command arriving on the final dwell cycle is chained immediately.
        if (abort) begin
          w_buf_full_nxt = 1'b0;
          w_home         = 1'b1;
        end else begin
          if (w_accept) begin
            w_buf_full_nxt = 1'b1;
            w_buf_x_nxt    = w_cmd_tx;
            w_buf_y_nxt    = w_cmd_ty;
          end
          if (w_expire) begin
            if (w_buf_full_nxt) begin
              w_tx_nxt       = w_buf_x_nxt;
              w_ty_nxt       = w_buf_y_nxt;
              w_buf_full_nxt = 1'b0;
              w_fwd          = 1'b1;
            end else begin
              w_home = 1'b1;
            end
          end
        end
`else
        if (abort || w_expire)
          w_home = 1'b1;
`endif
      end
      S_RET_X: begin
        if (w_expire) begin
          w_pos_x_nxt = r_pos_x - C_ONE;
          if (w_pos_x_nxt == '0)
            w_home = 1'b1;
        end
      end
      S_RET_Y: begin
        if (w_expire) begin
          w_pos_y_nxt = r_pos_y - C_ONE;
          if (w_pos_y_nxt == '0)
            w_home = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Leg selection skips zero-length legs in both directions of travel.
    if (w_fwd)
      w_state_nxt = (w_tx_nxt != w_pos_x_nxt) ? S_MOVE_X :
                    (w_ty_nxt != w_pos_y_nxt) ? S_MOVE_Y : S_PAUSE;
    else if (w_home)
      w_state_nxt = (w_pos_x_nxt != '0) ? S_RET_X :
                    (w_pos_y_nxt != '0) ? S_RET_Y : S_IDLE;

    w_load = (w_state_nxt != S_IDLE) && ((w_state_nxt != r_state) || w_expire);
    unique case (w_state_nxt)
      S_MOVE_X, S_RET_X: w_load_val = T_X;
      S_MOVE_Y, S_RET_Y: w_load_val = T_Y;
      S_PAUSE:           w_load_val = T_PAUSE;
      default:           w_load_val = '0;
    endcase
    w_remaining_nxt = w_load ? w_load_val : w_count - T_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_pos_x       <= '0;
      r_pos_y       <= '0;
      r_tx          <= '0;
      r_ty          <= '0;
      r_cmd_ready   <= 1'b1;
      r_x_run       <= 1'b0;
      r_x_dir       <= 1'b0;
      r_y_run       <= 1'b0;
      r_y_dir       <= 1'b0;
      r_motor_en    <= 1'b0;
      r_motor_state <= MOTOR_STOP;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pos_x       <= w_pos_x_nxt;
      r_pos_y       <= w_pos_y_nxt;
      r_tx          <= w_tx_nxt;
      r_ty          <= w_ty_nxt;
`ifdef COORD_CHAIN_EN
      r_cmd_ready   <= (w_state_nxt == S_IDLE) || ((w_state_nxt == S_PAUSE) && !w_buf_full_nxt);
`else
      r_cmd_ready   <= (w_state_nxt == S_IDLE);
`endif
      r_x_run       <= (w_state_nxt == S_MOVE_X) || (w_state_nxt == S_RET_X);
      r_x_dir       <= ((w_state_nxt == S_MOVE_X) && (w_tx_nxt > w_pos_x_nxt)) ? X_DIR_POS : X_DIR_NEG;
      r_y_run       <= (w_state_nxt == S_MOVE_Y) || (w_state_nxt == S_RET_Y);
      r_y_dir       <= (w_state_nxt == S_RET_Y) ? Y_DIR_NEG :
                       (w_state_nxt != S_MOVE_Y) ? 1'b0 :
                       (w_ty_nxt > w_pos_y_nxt) ? Y_DIR_POS : Y_DIR_NEG;
      r_motor_en    <= (w_state_nxt == S_PAUSE);
      r_motor_state <= (w_state_nxt == S_PAUSE) ?
                       reel_phase(64'(w_remaining_nxt), PAUSE_TICKS, REEL_TICKS) : MOTOR_STOP;
      r_busy        <= (w_state_nxt != S_IDLE);
      r_done        <= (r_state != S_IDLE) && (w_state_nxt == S_IDLE);
    end
  end

`ifdef COORD_CHAIN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf_full <= 1'b0;
      r_buf_x    <= '0;
      r_buf_y    <= '0;
    end else begin
      r_buf_full <= w_buf_full_nxt;
      r_buf_x    <= w_buf_x_nxt;
      r_buf_y    <= w_buf_y_nxt;
    end
  end
`endif

  assign cmd_ready   = r_cmd_ready;
  assign x_run       = r_x_run;
  assign x_dir       = r_x_dir;
  assign y_run       = r_y_run;
  assign y_dir       = r_y_dir;
  assign motor_en    = r_motor_en;
  assign motor_state = r_motor_state;
  assign busy        = r_busy;
  assign done        = r_done;
  assign pos_x       = r_pos_x;
  assign pos_y       = r_pos_y;

endmodule

// File: tb/tb_grid_nav_controller.sv
// Directed bench for grid_nav_controller with short tick parameters (X=4, Y=6, pause 20, reel 8).
module tb_grid_nav_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] cmd_x = '0;
  logic [3:0] cmd_y = '0;
  logic       cmd_ready, x_run, x_dir, y_run, y_dir, motor_en, busy, done;
  logic [1:0] motor_state;
  logic [3:0] pos_x, pos_y;

  int checks = 0;
  int failures = 0;

  grid_nav_controller #(
    .COORD_W(4), .MAX_X(7), .MAX_Y(7), .TIMER_W(32),
    .X_UNIT_TICKS(4), .Y_UNIT_TICKS(6), .PAUSE_TICKS(20), .REEL_TICKS(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .abort(abort),
    .x_run(x_run), .x_dir(x_dir), .y_run(y_run), .y_dir(y_dir),
    .motor_en(motor_en), .motor_state(motor_state), .busy(busy), .done(done),
    .pos_x(pos_x), .pos_y(pos_y)
  );

  always #5 clk = ~clk;

  // Returns 1ns after the accepting edge, i.e. inside cycle N+1.
  task automatic send_cmd(input logic [3:0] x, input logic [3:0] y, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    cmd_x = x; cmd_y = y; cmd_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (cmd_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
  endtask

  // Per-cycle tally of drive activity until the done pulse (inclusive).
  task automatic collect(input int max_cyc, output int xp, output int xn, output int yp,
                         output int yn, output int rev, output int fwd, output int stp,
                         output int dn, output int cyc, output bit to);
    xp = 0; xn = 0; yp = 0; yn = 0; rev = 0; fwd = 0; stp = 0; dn = 0; cyc = 0; to = 1'b1;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      if (x_run) begin if (x_dir) xp++; else xn++; end
      if (y_run) begin if (!y_dir) yp++; else yn++; end
      if (motor_en) begin
        if (motor_state == 2'b10) rev++;
        else if (motor_state == 2'b01) fwd++;
        else stp++;
      end
      if (done) begin dn++; cyc = c; to = 1'b0; break; end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({x_run, x_dir, y_run, y_dir, motor_en, busy, done} !== 7'b0) begin failures++; $display("FAIL rst_outs got=%b exp=0000000", {x_run, x_dir, y_run, y_dir, motor_en, busy, done}); end
    checks++; if (motor_state !== 2'b00) begin failures++; $display("FAIL rst_motor got=%b exp=00", motor_state); end
    checks++; if ({pos_x, pos_y} !== 8'h00) begin failures++; $display("FAIL rst_pos got=%h exp=00", {pos_x, pos_y}); end
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", cmd_ready); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if ({cmd_ready, busy} !== 2'b10) begin failures++; $display("FAIL post_rst got=%b exp=10", {cmd_ready, busy}); end
  endtask

  task automatic test_basic_trip;
    bit ok, to; int xp, xn, yp, yn, rev, fwd, stp, dn, cyc;
    send_cmd(4'd2, 4'd3, ok);
    checks++; if (!ok) begin failures++; $display("FAIL t1_accept got=0 exp=1"); end
    checks++; if ({x_run, x_dir, y_run, busy, cmd_ready} !== 5'b11010) begin failures++; $display("FAIL t1_latency got=%b exp=11010", {x_run, x_dir, y_run, busy, cmd_ready}); end
    collect(200, xp, xn, yp, yn, rev, fwd, stp, dn, cyc, to);
    checks++; if (to) begin failures++; $display("FAIL t1_timeout got=1 exp=0"); end
    checks++; if (xp !== 8) begin failures++; $display("FAIL t1_xplus got=%0d exp=8", xp); end
    checks++; if (yp !== 18) begin failures++; $display("FAIL t1_yplus got=%0d exp=18", yp); end
    checks++; if ({rev, fwd, stp} !== {32'd8, 32'd8, 32'd4}) begin failures++; $display("FAIL t1_reel got=%0d/%0d/%0d exp=8/8/4", rev, fwd, stp); end
    checks++; if (xn !== 8) begin failures++; $display("FAIL t1_xret got=%0d exp=8", xn); end
    checks++; if (yn !== 18) begin failures++; $display("FAIL t1_yret got=%0d exp=18", yn); end
    checks++; if (cyc !== 73) begin failures++; $display("FAIL t1_done_cycle got=%0d exp=73", cyc); end
    @(negedge clk);
    checks++; if ({done, busy, pos_x, pos_y} !== 10'b0) begin failures++; $display("FAIL t1_home got=%b exp=0", {done, busy, pos_x, pos_y}); end
  endtask

  task automatic test_zero_target;
    bit ok, to; int xp, xn, yp, yn, rev, fwd, stp, dn, cyc;
    repeat (2) @(negedge clk);
    send_cmd(4'd0, 4'd0, ok);
    checks++; if ({ok, motor_en, motor_state, x_run, y_run} !== 6'b111000) begin failures++; $display("FAIL t2_start got=%b exp=111000", {ok, motor_en, motor_state, x_run, y_run}); end
    collect(200, xp, xn, yp, yn, rev, fwd, stp, dn, cyc, to);
    checks++; if (xp + xn + yp + yn !== 0) begin failures++; $display("FAIL t2_no_run got=%0d exp=0", xp + xn + yp + yn); end
    checks++; if ({rev, fwd, stp} !== {32'd8, 32'd8, 32'd4}) begin failures++; $display("FAIL t2_reel got=%0d/%0d/%0d exp=8/8/4", rev, fwd, stp); end
    checks++; if ({to, dn, cyc} !== {1'b0, 32'd1, 32'd21}) begin failures++; $display("FAIL t2_done got=to%0d dn%0d cyc%0d exp=to0 dn1 cyc21", to, dn, cyc); end
  endtask

  task automatic test_clamp;
    bit ok, to; int xp, xn, yp, yn, rev, fwd, stp, dn, cyc;
    repeat (2) @(negedge clk);
    send_cmd(4'd9, 4'd1, ok);
    collect(300, xp, xn, yp, yn, rev, fwd, stp, dn, cyc, to);
    checks++; if (xp !== 28) begin failures++; $display("FAIL t3_clamp_x got=%0d exp=28", xp); end
    checks++; if ({xn, yp, yn} !== {32'd28, 32'd6, 32'd6}) begin failures++; $display("FAIL t3_legs got=%0d/%0d/%0d exp=28/6/6", xn, yp, yn); end
    checks++; if ({to, cyc} !== {1'b0, 32'd89}) begin failures++; $display("FAIL t3_done got=to%0d cyc%0d exp=to0 cyc89", to, cyc); end
  endtask

  task automatic test_abort_move;
    bit ok, to; int xp, xn, yp, yn, rev, fwd, stp, dn, cyc; int xp1; logic [3:0] px6;
    xp1 = 0; px6 = '0;
    repeat (2) @(negedge clk);
    send_cmd(4'd3, 4'd2, ok);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (x_run && x_dir) xp1++;
      if (c == 6) begin px6 = pos_x; abort = 1'b1; end
    end
    @(posedge clk); #1;
    abort = 1'b0;
    checks++; if ({xp1, px6} !== {32'd6, 4'd1}) begin failures++; $display("FAIL t4_pre_abort got=%0d/%0d exp=6/1", xp1, px6); end
    checks++; if ({x_run, x_dir, pos_x} !== {1'b1, 1'b0, 4'd1}) begin failures++; $display("FAIL t4_ret_start got=%b exp=1_0_0001", {x_run, x_dir, pos_x}); end
    collect(200, xp, xn, yp, yn, rev, fwd, stp, dn, cyc, to);
    checks++; if ({xn, xp, yp + yn} !== {32'd4, 32'd0, 32'd0}) begin failures++; $display("FAIL t4_ret got=%0d/%0d/%0d exp=4/0/0", xn, xp, yp + yn); end
    checks++; if (rev + fwd + stp !== 0) begin failures++; $display("FAIL t4_no_pause got=%0d exp=0", rev + fwd + stp); end
    checks++; if ({to, dn, cyc} !== {1'b0, 32'd1, 32'd5}) begin failures++; $display("FAIL t4_done got=to%0d dn%0d cyc%0d exp=to0 dn1 cyc5", to, dn, cyc); end
  endtask

  task automatic test_abort_pause;
    bit ok, to, seen; int xp, xn, yp, yn, rev, fwd, stp, dn, cyc;
    seen = 1'b0;
    repeat (2) @(negedge clk);
    send_cmd(4'd1, 4'd0, ok);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (motor_en) begin seen = 1'b1; break; end
    end
    checks++; if (!seen) begin failures++; $display("FAIL t5_pause_reached got=0 exp=1"); end
`ifdef COORD_CHAIN_EN
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL t5_pause_ready got=%b exp=1", cmd_ready); end
`else
    checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL t5_pause_ready got=%b exp=0", cmd_ready); end
`endif
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++; if ({motor_en, motor_state, x_run, x_dir} !== 5'b00010) begin failures++; $display("FAIL t5_motor_off got=%b exp=00010", {motor_en, motor_state, x_run, x_dir}); end
    collect(200, xp, xn, yp, yn, rev, fwd, stp, dn, cyc, to);
    checks++; if ({xn, rev + fwd + stp, dn, cyc} !== {32'd4, 32'd0, 32'd1, 32'd5}) begin failures++; $display("FAIL t5_ret got=xn%0d m%0d dn%0d cyc%0d exp=xn4 m0 dn1 cyc5", xn, rev + fwd + stp, dn, cyc); end
  endtask

  task automatic test_abort_idle;
    bit ok, to; int xp, xn, yp, yn, rev, fwd, stp, dn, cyc;
    repeat (2) @(negedge clk);
    abort = 1'b1;
    send_cmd(4'd0, 4'd1, ok);
    abort = 1'b0;
    checks++; if ({ok, y_run, y_dir, busy} !== 4'b1101) begin failures++; $display("FAIL t5_idle_abort got=%b exp=1101", {ok, y_run, y_dir, busy}); end
    collect(200, xp, xn, yp, yn, rev, fwd, stp, dn, cyc, to);
    checks++; if ({yp, yn, rev, cyc} !== {32'd6, 32'd6, 32'd8, 32'd33}) begin failures++; $display("FAIL t5_idle_trip got=%0d/%0d/%0d/%0d exp=6/6/8/33", yp, yn, rev, cyc); end
  endtask

`ifdef COORD_CHAIN_EN
  task automatic test_chain;
    bit ok, to, seen; int xp, xn, yp, yn, rev, fwd, stp, dn, cyc;
    seen = 1'b0;
    repeat (2) @(negedge clk);
    send_cmd(4'd2, 4'd2, ok);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (motor_en) begin seen = 1'b1; break; end
    end
    send_cmd(4'd1, 4'd4, ok);
    checks++; if ({seen, ok, cmd_ready, motor_en} !== 4'b1101) begin failures++; $display("FAIL t6_buffer got=%b exp=1101", {seen, ok, cmd_ready, motor_en}); end
    collect(300, xp, xn, yp, yn, rev, fwd, stp, dn, cyc, to);
    checks++; if ({xp, xn} !== {32'd0, 32'd8}) begin failures++; $display("FAIL t6_x got=%0d/%0d exp=0/8", xp, xn); end
    checks++; if ({yp, yn} !== {32'd12, 32'd24}) begin failures++; $display("FAIL t6_y got=%0d/%0d exp=12/24", yp, yn); end
    checks++; if ({to, dn} !== {1'b0, 32'd1}) begin failures++; $display("FAIL t6_done got=to%0d dn%0d exp=to0 dn1", to, dn); end
  endtask
`endif

  task automatic test_reset_mid_trip;
    bit ok;
    repeat (2) @(negedge clk);
    send_cmd(4'd3, 4'd3, ok);
    repeat (10) @(negedge clk);
    checks++; if ({x_run, pos_x} !== {1'b1, 4'd2}) begin failures++; $display("FAIL t7_mid got=%b exp=1_0010", {x_run, pos_x}); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({x_run, busy, pos_x, cmd_ready} !== {1'b0, 1'b0, 4'd0, 1'b1}) begin failures++; $display("FAIL t7_async_rst got=%b exp=0_0_0000_1", {x_run, busy, pos_x, cmd_ready}); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset;
    test_basic_trip;
    test_zero_target;
    test_clamp;
    test_abort_move;
    test_abort_pause;
    test_abort_idle;
`ifdef COORD_CHAIN_EN
    test_chain;
`endif
    test_reset_mid_trip;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
